// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Instruction buffer between the instruction-memory side and the decode
// stage. Holds up to DEPTH {pc, instruction} pairs and presents the oldest
// pair to decode. Decode stalls apply back-pressure. A branch redirect
// (flush) discards every buffered entry.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   pc_i       pc of the incoming instruction
//   instr_i    incoming instruction word
//   in_valid   pc_i/instr_i are valid this cycle
//   in_ready   queue accepts a push this cycle
//   pc_o       pc of the head entry (0 when empty)
//   instr_o    instruction of the head entry (NOP_INSTR when empty)
//   out_valid  head entry is valid
//   stall_i    decode stall; the head is not consumed
//   flush_i    branch redirect; discard all entries
//   count_o    number of occupied entries, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 4,
    parameter int                 CNT_W     = $clog2(DEPTH) + 1,
    parameter logic [WIDTH-1:0]   NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  pc_i,
    input  logic [WIDTH-1:0]  instr_i,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  pc_o,
    output logic [WIDTH-1:0]  instr_o,
    output logic              out_valid,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  count_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // Handshake. in_ready deliberately ignores a same-cycle pop when full,
    // so the source never sees a combinational path through stall_i.
    // Dropping in_ready during flush tells the source its word was lost.
    always_comb begin
        in_ready  = (count_q != FULL_CNT) & ~flush_i;
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & ~stall_i & ~flush_i;
    end

    // Next-state for pointers and occupancy. Flush overrides everything;
    // pointers are power-of-two wide so they wrap without explicit compare.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= pc_i;
            instr_mem[wr_ptr_q] <= instr_i;
        end
    end

    // Empty queue presents a harmless NOP so decode never sees stale data.
    always_comb begin
        count_o = count_q;
        if (out_valid) begin
            pc_o    = pc_mem[rd_ptr_q];
            instr_o = instr_mem[rd_ptr_q];
        end else begin
            pc_o    = '0;
            instr_o = NOP_INSTR;
        end
    end

endmodule
